sn74hc595_rx: RTL and testbench

Clocked receiver model of the SN74HC595 serial-to-parallel chain driven by the traffic-light top's `SN74HC595_data` / `SN74HC595_data_clk` / `SN74HC595_refresh_clk` outputs. It synchronises the three pins into the system clock domain and shifts on data-clock rising edges. On refresh rising edges it latches the chain contents onto a parallel bus, reproducing what the physical '595 outputs show. It also reports frame integrity (bit count per refresh) and a frame counter, so benches and on-board debug can check the serialiser end to end.

---
 rtl/sn74hc595_rx.sv | 107 ++++++++++
 tb/tb_sn74hc595_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sn74hc595_rx.sv
// rtl/sn74hc595_rx.sv - clocked receiver model of a cascaded SN74HC595 serial-to-parallel chain
//
// Ports:
//   clk                    system clock
//   rst_n                  asynchronous active-low reset
//   SN74HC595_data         serial data pin (SER)
//   SN74HC595_data_clk     shift clock pin (SRCLK), rising-edge active
//   SN74HC595_refresh_clk  latch clock pin (RCLK), rising-edge active
//   q_out                  latched parallel outputs, MSB = first bit shifted in
//   q_valid                one-cycle pulse when q_out updates
//   frame_err              one-cycle pulse with q_valid when shift count != CHAIN_BITS
//   frame_cnt              refresh edges since reset, wrapping
//   shift_reg              live shift-register contents
module sn74hc595_rx #(
  parameter int CHAIN_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SN74HC595_data,
  input  logic                  SN74HC595_data_clk,
  input  logic                  SN74HC595_refresh_clk,
  output logic [CHAIN_BITS-1:0] q_out,
  output logic                  q_valid,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt,
  output logic [CHAIN_BITS-1:0] shift_reg
);

  localparam logic [6:0] CNT_MAX    = 7'd127;
  localparam logic [6:0] CHAIN_CNT  = 7'(CHAIN_BITS);

  // Synchronisers: stage 0 samples the pin, stage SYNC_STAGES-1 is the safe copy.
  logic [SYNC_STAGES-1:0] ser_sync;
  logic [SYNC_STAGES-1:0] srclk_sync;
  logic [SYNC_STAGES-1:0] rclk_sync;

  // One-flop history of the synchronised clocks for rising-edge detection.
  logic srclk_d;
  logic rclk_d;

  logic [6:0] bit_cnt;

  logic sdata;
  logic srclk_rise;
  logic rclk_rise;

  assign sdata      = ser_sync[SYNC_STAGES-1];
  assign srclk_rise = srclk_sync[SYNC_STAGES-1] & ~srclk_d;
  assign rclk_rise  = rclk_sync[SYNC_STAGES-1] & ~rclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_sync   <= '0;
      srclk_sync <= '0;
      rclk_sync  <= '0;
      srclk_d    <= 1'b0;
      rclk_d     <= 1'b0;
    end else begin
      ser_sync   <= {ser_sync[SYNC_STAGES-2:0], SN74HC595_data};
      srclk_sync <= {srclk_sync[SYNC_STAGES-2:0], SN74HC595_data_clk};
      rclk_sync  <= {rclk_sync[SYNC_STAGES-2:0], SN74HC595_refresh_clk};
      srclk_d    <= srclk_sync[SYNC_STAGES-1];
      rclk_d     <= rclk_sync[SYNC_STAGES-1];
    end
  end

  // Shift path. Nonblocking semantics mean a same-cycle latch below still
  // sees the pre-shift register value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (srclk_rise) begin
      shift_reg <= {shift_reg[CHAIN_BITS-2:0], sdata};
    end
  end

  // Bit counter: a refresh clears it, but a coincident shift counts as the
  // first bit of the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (rclk_rise) begin
      bit_cnt <= srclk_rise ? 7'd1 : 7'd0;
    end else if (srclk_rise && bit_cnt != CNT_MAX) begin
      bit_cnt <= bit_cnt + 7'd1;
    end
  end

  // Latch path and frame integrity pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_out     <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      q_valid   <= rclk_rise;
      frame_err <= rclk_rise && (bit_cnt != CHAIN_CNT);
      if (rclk_rise) begin
        q_out     <= shift_reg;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sn74hc595_rx.sv
// tb/tb_sn74hc595_rx.sv - self-checking bench for sn74hc595_rx
module tb_sn74hc595_rx;

  localparam int CB   = 16;
  localparam int SS   = 2;
  localparam int HOLD = SS + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ser = 1'b0;
  logic          srclk = 1'b0;
  logic          rclk = 1'b0;
  logic [CB-1:0] q_out;
  logic          q_valid;
  logic          frame_err;
  logic [15:0]   frame_cnt;
  logic [CB-1:0] shift_reg;

  sn74hc595_rx #(.CHAIN_BITS(CB), .SYNC_STAGES(SS)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .SN74HC595_data        (ser),
    .SN74HC595_data_clk    (srclk),
    .SN74HC595_refresh_clk (rclk),
    .q_out                 (q_out),
    .q_valid               (q_valid),
    .frame_err             (frame_err),
    .frame_cnt             (frame_cnt),
    .shift_reg             (shift_reg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pulse monitor: counts q_valid / frame_err pulses and records latched data.
  int            v_cnt = 0;
  int            e_cnt = 0;
  logic [CB-1:0] last_q = '0;

  always @(negedge clk) begin
    if (q_valid) begin
      v_cnt++;
      last_q = q_out;
      if (frame_err) e_cnt++;
    end
    total++;
    if (frame_err && !q_valid) begin
      bad++;
      $display("FAIL err_without_valid act=1 exp=0 t=%0t", $time);
    end
  end

  // Reference model: full bit history since reset plus bits since last refresh.
  bit hist[$];
  int since  = 0;
  int frames = 0;

  function automatic logic [CB-1:0] model_q();
    logic [CB-1:0] v;
    int n;
    v = '0;
    n = hist.size();
    for (int i = 0; i < CB; i++)
      if (n - 1 - i >= 0) v[i] = hist[n-1-i];
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic phase();
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ser = 1'b0; srclk = 1'b0; rclk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    hist.delete();
    since = 0;
    frames = 0;
  endtask

  task automatic shift_bit(input bit b);
    ser = b;
    phase();
    srclk = 1'b1;
    phase();
    srclk = 1'b0;
    phase();
    hist.push_back(b);
    if (hist.size() > 64) void'(hist.pop_front());
    since++;
  endtask

  task automatic refresh();
    rclk = 1'b1;
    phase();
    rclk = 1'b0;
    phase();
    since = 0;
    frames++;
  endtask

  task automatic shift_word(input int nbits, input logic [31:0] data);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(data[i]);
  endtask

  typedef struct {
    bit          rst;
    int          nbits;
    logic [31:0] data;
    int          nref;
    logic [15:0] q;
    int          errs;
    int          valids;
    int          cnt;
  } vec_t;

  vec_t tbl[6];

  int            v0, e0, n, lat;
  logic [CB-1:0] exp_q;
  int            exp_err;

  initial begin
    tbl[0] = '{1'b1, 16, 32'h0000A5C3, 1, 16'hA5C3, 0, 1, 1};
    tbl[1] = '{1'b0,  0, 32'h00000000, 2, 16'hA5C3, 2, 2, 3};
    tbl[2] = '{1'b1, 15, 32'h00007FFF, 1, 16'h7FFF, 1, 1, 1};
    tbl[3] = '{1'b1, 17, 32'h00011234, 1, 16'h1234, 1, 1, 1};
    tbl[4] = '{1'b0, 16, 32'h00000000, 1, 16'h0000, 0, 1, 2};
    tbl[5] = '{1'b0, 16, 32'h0000FFFF, 1, 16'hFFFF, 0, 1, 3};

    // Reset state, sampled while reset is still held.
    repeat (2) @(negedge clk);
    chk("rst_q_out", q_out, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_shift_reg", shift_reg, 0);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) do_reset();
      shift_word(tbl[i].nbits, tbl[i].data);
      v0 = v_cnt; e0 = e_cnt;
      for (int r = 0; r < tbl[i].nref; r++) refresh();
      chk($sformatf("vec%0d_q", i), last_q, tbl[i].q);
      chk($sformatf("vec%0d_valids", i), v_cnt - v0, tbl[i].valids);
      chk($sformatf("vec%0d_errs", i), e_cnt - e0, tbl[i].errs);
      chk($sformatf("vec%0d_cnt", i), frame_cnt, tbl[i].cnt);
    end

    // Latch latency: update lands SS edges after the edge that samples RCLK.
    do_reset();
    shift_word(16, 32'hA5C3);
    v0 = v_cnt;
    rclk = 1'b1;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (q_valid) begin lat = c; break; end
    end
    chk("latency", lat, SS + 1);
    chk("latency_q", q_out, 16'hA5C3);
    @(posedge clk); #1;
    chk("valid_one_cycle", q_valid, 0);
    rclk = 1'b0;
    phase();
    chk("latency_pulses", v_cnt - v0, 1);

    // Simultaneous shift and refresh on the 16th bit.
    do_reset();
    shift_word(15, 32'h7FFF);
    v0 = v_cnt; e0 = e_cnt;
    ser = 1'b0;
    phase();
    srclk = 1'b1; rclk = 1'b1;
    phase();
    srclk = 1'b0; rclk = 1'b0;
    phase();
    chk("simul_q", last_q, 16'h7FFF);
    chk("simul_err", e_cnt - e0, 1);
    chk("simul_shift_reg", shift_reg, 16'hFFFE);
    shift_word(15, 32'h7FFF);
    v0 = v_cnt; e0 = e_cnt;
    refresh();
    chk("simul_next_err", e_cnt - e0, 0);
    chk("simul_next_valid", v_cnt - v0, 1);
    chk("simul_next_q", last_q, 16'h7FFF);

    // Asynchronous reset mid-frame.
    do_reset();
    shift_word(16, 32'hA5C3);
    refresh();
    shift_word(8, 32'hFF);
    chk("pre_rst_shift_reg", shift_reg, 16'hC3FF);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_q_out", q_out, 0);
    chk("async_shift_reg", shift_reg, 0);
    chk("async_frame_cnt", frame_cnt, 0);
    chk("async_q_valid", q_valid, 0);
    chk("async_frame_err", frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    hist.delete(); since = 0; frames = 0;
    shift_word(16, 32'h00FF);
    e0 = e_cnt;
    refresh();
    chk("post_rst_q", last_q, 16'h00FF);
    chk("post_rst_cnt", frame_cnt, 1);
    chk("post_rst_err", e_cnt - e0, 0);

    // Randomised frames against the history model.
    do_reset();
    for (int f = 0; f < 10; f++) begin
      n = ($urandom_range(0, 1) == 1) ? CB : int'($urandom_range(0, 20));
      for (int i = 0; i < n; i++) shift_bit(1'($urandom_range(0, 1)));
      exp_q   = model_q();
      exp_err = (since != CB) ? 1 : 0;
      v0 = v_cnt; e0 = e_cnt;
      refresh();
      chk($sformatf("rnd%0d_valid", f), v_cnt - v0, 1);
      chk($sformatf("rnd%0d_q", f), last_q, exp_q);
      chk($sformatf("rnd%0d_err", f), e_cnt - e0, exp_err);
      chk($sformatf("rnd%0d_cnt", f), frame_cnt, frames);
      chk($sformatf("rnd%0d_shift_reg", f), shift_reg, model_q());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
